// File: rtl/factor_display_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// factor_display_sequencer_pkg
// Shared definitions for the factor display sequencer and its 7-segment
// decoder. It holds the sequencer state encoding, the factor vector geometry
// and the segment patterns, {g,f,e,d,c,b,a}, active high.
// -----------------------------------------------------------------------------
package factor_display_sequencer_pkg;

  // factors[i] set means the number is divisible by i + FACTOR_BASE
  localparam int FACTOR_BITS = 18;
  localparam int FACTOR_BASE = 2;

  typedef enum logic [2:0] {
    SETTLE,
    SCAN,
    SHOW,
    GAP,
    STATIC
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_P     = 7'h73;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/factor_display_sequencer_seg7_decoder.sv
// -----------------------------------------------------------------------------
// seg7_decoder
// Combinational decimal digit to 7-segment pattern. Codes 10..15 are not
// decimal digits and decode to a blank display.
// Ports:
//   i_digit  in  4  digit 0..9
//   o_seg    out 7  {g,f,e,d,c,b,a}, active high
// -----------------------------------------------------------------------------
module seg7_decoder
  import factor_display_sequencer_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/factor_display_sequencer.sv
// -----------------------------------------------------------------------------
// factor_display_sequencer
// Sits behind the factorizer. After every change of the input number it waits
// for the factorizer to settle and takes a snapshot of factors/is_prime. It
// then steps each set factor (2..19) onto a single 7-segment digit, holding
// each one for DWELL_TICKS slow ticks. A gap marker is shown between passes:
// 'P' for a prime, otherwise blank. A number with no factor in 2..19 shows a
// static 'P' (prime) or '-' (not prime).
// Ports:
//   clk             in  1   clock
//   reset           in  1   synchronous, active-high reset
//   number          in  8   value that also drives the factorizer
//   factors         in  18  bit i set: divisible by i+2
//   is_prime        in  1   factorizer prime flag
//   tick            in  1   single-cycle slow advance strobe
//   seg             out 7   {g,f,e,d,c,b,a}, active high
//   dp              out 1   displayed factor is >= 10
//   factor_value    out 5   displayed factor, 0 when none
//   showing_factor  out 1   a factor is on the display
// -----------------------------------------------------------------------------
module factor_display_sequencer
  import factor_display_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int DWELL_TICKS   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             number,
  input  logic [FACTOR_BITS-1:0] factors,
  input  logic                   is_prime,
  input  logic                   tick,
  output logic [6:0]             seg,
  output logic                   dp,
  output logic [4:0]             factor_value,
  output logic                   showing_factor
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [7:0]       DWELL_LOAD  = 8'(DWELL_TICKS);
  localparam logic [4:0]       LAST_IDX    = 5'(FACTOR_BITS - 1);

  state_t                 r_state;
  logic [CNT_W-1:0]       r_settle_cnt;
  logic [4:0]             r_idx;
  logic [7:0]             r_number_q;
  logic [FACTOR_BITS-1:0] r_snap_f;
  logic                   r_snap_p;
  logic [7:0]             r_dwell;
  logic [6:0]             r_seg;
  logic                   r_dp;
  logic [4:0]             r_factor_value;
  logic                   r_showing;

  state_t                 w_state_next;
  logic [CNT_W-1:0]       w_settle_next;
  logic [4:0]             w_idx_next;
  logic [FACTOR_BITS-1:0] w_snap_f_next;
  logic                   w_snap_p_next;
  logic [7:0]             w_dwell_next;
  logic [6:0]             w_seg_next;
  logic                   w_dp_next;
  logic [4:0]             w_fv_next;
  logic                   w_showing_next;

  logic [4:0]             w_shown;
  logic [3:0]             w_digit;
  logic [6:0]             w_seg_dec;

  // ---------------------------------------------------------------------------
  // Next-state logic. A number change overrides everything, including a tick
  // arriving in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_settle_next = r_settle_cnt;
    w_idx_next    = r_idx;
    w_snap_f_next = r_snap_f;
    w_snap_p_next = r_snap_p;
    w_dwell_next  = r_dwell;

    if (number != r_number_q) begin
      w_state_next  = SETTLE;
      w_settle_next = SETTLE_LOAD;
    end else begin
      case (r_state)
        SETTLE: begin
          if (r_settle_cnt == '0) begin
            w_snap_f_next = factors;
            w_snap_p_next = is_prime;
            w_idx_next    = '0;
            w_state_next  = (factors == '0) ? STATIC : SCAN;
          end else begin
            w_settle_next = r_settle_cnt - CNT_ONE;
          end
        end

        // One candidate bit per clock; ticks have no effect here.
        SCAN: begin
          if (r_snap_f[r_idx]) begin
            w_state_next = SHOW;
            w_dwell_next = DWELL_LOAD;
          end else if (r_idx == LAST_IDX) begin
            w_state_next = GAP;
            w_idx_next   = '0;
            w_dwell_next = DWELL_LOAD;
          end else begin
            w_idx_next = r_idx + 5'd1;
          end
        end

        // The dwell counter is loaded on entry regardless of tick, so a tick
        // landing in the entry cycle never shortens the hold.
        SHOW: begin
          if (tick) begin
            if (r_dwell <= 8'd1) begin
              if (r_idx == LAST_IDX) begin
                w_state_next = GAP;
                w_idx_next   = '0;
                w_dwell_next = DWELL_LOAD;
              end else begin
                w_state_next = SCAN;
                w_idx_next   = r_idx + 5'd1;
              end
            end else begin
              w_dwell_next = r_dwell - 8'd1;
            end
          end
        end

        GAP: begin
          if (tick) begin
            if (r_dwell <= 8'd1) begin
              w_state_next = SCAN;
              w_idx_next   = '0;
            end else begin
              w_dwell_next = r_dwell - 8'd1;
            end
          end
        end

        STATIC: begin
          w_state_next = STATIC;
        end

        default: begin
          w_state_next  = SETTLE;
          w_settle_next = SETTLE_LOAD;
        end
      endcase
    end
  end

  // Displayed factor for the upcoming state, split into tens flag and units.
  assign w_shown = w_idx_next + 5'(FACTOR_BASE);
  assign w_digit = (w_shown >= 5'd10) ? 4'(w_shown - 5'd10) : w_shown[3:0];

  seg7_decoder u_seg7_decoder (
    .i_digit (w_digit),
    .o_seg   (w_seg_dec)
  );

  // Outputs are derived from the next state so the registered outputs line up
  // with the state they describe.
  always_comb begin
    w_seg_next     = SEG_BLANK;
    w_dp_next      = 1'b0;
    w_fv_next      = '0;
    w_showing_next = 1'b0;
    case (w_state_next)
      SHOW: begin
        w_seg_next     = w_seg_dec;
        w_dp_next      = (w_shown >= 5'd10);
        w_fv_next      = w_shown;
        w_showing_next = 1'b1;
      end
      GAP:     w_seg_next = w_snap_p_next ? SEG_P : SEG_BLANK;
      STATIC:  w_seg_next = w_snap_p_next ? SEG_P : SEG_DASH;
      default: w_seg_next = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= SETTLE;
      r_settle_cnt   <= SETTLE_LOAD;
      r_idx          <= '0;
      r_number_q     <= '0;
      r_snap_f       <= '0;
      r_snap_p       <= 1'b0;
      r_dwell        <= '0;
      r_seg          <= SEG_BLANK;
      r_dp           <= 1'b0;
      r_factor_value <= '0;
      r_showing      <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_settle_cnt   <= w_settle_next;
      r_idx          <= w_idx_next;
      r_number_q     <= number;
      r_snap_f       <= w_snap_f_next;
      r_snap_p       <= w_snap_p_next;
      r_dwell        <= w_dwell_next;
      r_seg          <= w_seg_next;
      r_dp           <= w_dp_next;
      r_factor_value <= w_fv_next;
      r_showing      <= w_showing_next;
    end
  end

  assign seg            = r_seg;
  assign dp             = r_dp;
  assign factor_value   = r_factor_value;
  assign showing_factor = r_showing;

endmodule

// File: tb/tb_factor_display_sequencer.sv
module tb_factor_display_sequencer;

  localparam int SETTLE_CYCLES = 4;
  localparam int DWELL_TICKS   = 2;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic [7:0]  number = 8'd0;
  logic        tick   = 1'b0;
  logic [17:0] factors;
  logic        is_prime;
  logic [6:0]  seg;
  logic        dp;
  logic [4:0]  factor_value;
  logic        showing_factor;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_mode = 3;   // 0: every 8 clks, 1: random, 2: every clk, 3: never
  int tick_div  = 0;
  bit chk_en    = 1'b0;
  int seen[$];

  logic [6:0] digit_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always #5 clk = ~clk;

  // ---------------- factorizer stand-in: pure arithmetic, 4-clock latency ----
  function automatic logic [17:0] calc_factors(input logic [7:0] n);
    logic [17:0] f;
    f = '0;
    for (int i = 0; i < 18; i++)
      if ((int'(n) % (i + 2)) == 0) f[i] = 1'b1;
    return f;
  endfunction

  function automatic logic calc_prime(input logic [7:0] n);
    if (int'(n) < 2) return 1'b0;
    for (int d = 2; d < int'(n); d++)
      if ((int'(n) % d) == 0) return 1'b0;
    return 1'b1;
  endfunction

  logic [7:0] num_d1 = 8'd0, num_d2 = 8'd0, num_d3 = 8'd0, num_d4 = 8'd0;
  always @(posedge clk) begin
    num_d1 <= number;
    num_d2 <= num_d1;
    num_d3 <= num_d2;
    num_d4 <= num_d3;
  end
  assign factors  = calc_factors(num_d4);
  assign is_prime = calc_prime(num_d4);

  factor_display_sequencer #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .DWELL_TICKS   (DWELL_TICKS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .number         (number),
    .factors        (factors),
    .is_prime       (is_prime),
    .tick           (tick),
    .seg            (seg),
    .dp             (dp),
    .factor_value   (factor_value),
    .showing_factor (showing_factor)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model --------------------------------------
  // The display is a schedule: after a snapshot (or after a gap) the next item
  // is the lowest set factor bit q, appearing q+1 clocks later; after factor
  // bit p the next set bit q appears q-p clocks later, or the gap appears
  // 17-p clocks later when no higher bit is set. Each item holds for
  // DWELL_TICKS ticks, the entry-cycle tick not counting.
  int          m_mode;    // 0 settling, 1 running, 2 static
  int          m_cnt;
  logic [7:0]  m_num_q;
  logic [17:0] m_snap;
  logic        m_prime;
  int          m_cur;     // -1 blank, 0..17 factor bit, 18 gap
  int          m_next;
  int          m_wait;
  int          m_ticks;
  logic [6:0]  exp_seg = 7'd0;
  logic        exp_dp  = 1'b0;
  logic [4:0]  exp_fv  = 5'd0;
  logic        exp_sf  = 1'b0;

  task automatic find_next(input logic [17:0] s, input int p, output int item, output int delay);
    item  = 18;
    delay = 17 - p;
    for (int q = 17; q > p; q--)
      if (s[q]) begin
        item  = q;
        delay = q - p;
      end
  endtask

  task automatic model_step();
    int p, nx, d, v;
    if (reset) begin
      m_mode = 0; m_cnt = SETTLE_CYCLES; m_num_q = 8'd0;
      m_snap = '0; m_prime = 1'b0; m_cur = -1;
    end else if (number != m_num_q) begin
      m_num_q = number; m_mode = 0; m_cnt = SETTLE_CYCLES; m_cur = -1;
    end else if (m_mode == 0) begin
      if (m_cnt == 0) begin
        m_snap  = calc_factors(m_num_q);
        m_prime = calc_prime(m_num_q);
        if (m_snap == '0) m_mode = 2;
        else begin
          m_mode = 1;
          m_cur  = -1;
          find_next(m_snap, -1, m_next, m_wait);
        end
      end else m_cnt--;
    end else if (m_mode == 1) begin
      if (m_cur < 0) begin
        m_wait--;
        if (m_wait == 0) begin m_cur = m_next; m_ticks = DWELL_TICKS; end
      end else if (tick) begin
        m_ticks--;
        if (m_ticks == 0) begin
          p = (m_cur == 18) ? -1 : m_cur;
          find_next(m_snap, p, nx, d);
          if (d == 0) begin m_cur = nx; m_ticks = DWELL_TICKS; end
          else begin m_cur = -1; m_next = nx; m_wait = d; end
        end
      end
    end

    exp_seg = 7'h00; exp_dp = 1'b0; exp_fv = 5'd0; exp_sf = 1'b0;
    if (m_mode == 2) exp_seg = m_prime ? 7'h73 : 7'h40;
    else if (m_mode == 1 && m_cur == 18) exp_seg = m_prime ? 7'h73 : 7'h00;
    else if (m_mode == 1 && m_cur >= 0) begin
      v       = m_cur + 2;
      exp_fv  = 5'(v);
      exp_dp  = (v >= 10);
      exp_seg = digit_tab[v % 10];
      exp_sf  = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en)
      check("model_outputs", {18'd0, seg, dp, factor_value, showing_factor},
            {18'd0, exp_seg, exp_dp, exp_fv, exp_sf});
  end

  // ---------------- tick generator ----------------------------------------
  initial forever begin
    @(negedge clk);
    case (tick_mode)
      0: begin tick_div = (tick_div + 1) % 8; tick = (tick_div == 0); end
      1: tick = ($urandom_range(0, 3) == 0);
      2: tick = 1'b1;
      default: tick = 1'b0;
    endcase
  end

  // ---------------- helpers ----------------------------------------------
  task automatic collect(input int n, input int budget);
    logic       prev_sf;
    logic [4:0] prev_fv;
    seen.delete();
    prev_sf = showing_factor;
    prev_fv = factor_value;
    for (int c = 0; c < budget && seen.size() < n; c++) begin
      @(negedge clk);
      if (showing_factor && (!prev_sf || factor_value != prev_fv))
        seen.push_back(int'(factor_value));
      prev_sf = showing_factor;
      prev_fv = factor_value;
    end
    if (seen.size() < n) begin
      n_checks++; n_fail++;
      $display("FAIL collect_timeout: got %0d items, want %0d", seen.size(), n);
    end
  endtask

  task automatic wait_show(input int v, input int budget);
    int c;
    c = 0;
    while (!(showing_factor && int'(factor_value) == v) && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (c >= budget) begin
      n_checks++; n_fail++;
      $display("FAIL wait_show_%0d: got fv=%0d, want %0d within %0d clks", v, factor_value, v, budget);
    end
  endtask

  task automatic wait_gap_p(input int budget);
    int c;
    c = 0;
    while (!(seg == 7'h73 && !showing_factor) && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (c >= budget) begin
      n_checks++; n_fail++;
      $display("FAIL wait_gap_p: got seg=0x%0h, want 0x73 within %0d clks", seg, budget);
    end
  endtask

  // ---------------- directed + random stimulus ----------------------------
  initial begin
    int cnt, r, hold;
    logic [4:0] vals12 [6];
    vals12[0] = 5'd2; vals12[1] = 5'd3; vals12[2] = 5'd4;
    vals12[3] = 5'd6; vals12[4] = 5'd12; vals12[5] = 5'd2;

    tick_mode = 3;
    reset = 1'b1;
    number = 8'd0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_seg", 32'(seg), 32'h0);
    check("reset_dp", 32'(dp), 32'h0);
    check("reset_fv", 32'(factor_value), 32'h0);
    check("reset_sf", 32'(showing_factor), 32'h0);
    reset = 1'b0;

    // number=0: every factor 2..19 in order, tick every clock
    tick_mode = 2;
    collect(18, 400);
    for (int k = 0; k < 18; k++)
      if (k < seen.size()) check("all18_item", 32'(seen[k]), 32'(k + 2));

    // number=12, tick every 8 clocks: 2,3,4,6,12, gap, 2 ...
    number = 8'd12;
    tick_mode = 0;
    collect(6, 800);
    for (int k = 0; k < 6; k++)
      if (k < seen.size()) check("seq12_item", 32'(seen[k]), 32'(vals12[k]));
    wait_show(12, 300);
    check("f12_seg", 32'(seg), 32'h5B);
    check("f12_dp", 32'(dp), 32'h1);

    // number change 12 -> 18 while 4 is displayed
    wait_show(4, 300);
    number = 8'd18;
    @(negedge clk);
    check("chg_blank_sf", 32'(showing_factor), 32'h0);
    check("chg_blank_seg", 32'(seg), 32'h0);
    cnt = 0;
    while (!showing_factor && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("restart_fv", 32'(factor_value), 32'd2);
    check("restart_after_settle", 32'(cnt >= SETTLE_CYCLES), 32'h1);

    // number=23: prime without small factors, static 'P'
    number = 8'd23;
    tick_mode = 1;
    repeat (20) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("static23_seg", 32'(seg), 32'h73);
      check("static23_sf", 32'(showing_factor), 32'h0);
      repeat (25) @(negedge clk);
    end

    // number=1: static dash
    number = 8'd1;
    repeat (20) @(negedge clk);
    check("static1_seg", 32'(seg), 32'h40);
    check("static1_fv", 32'(factor_value), 32'h0);

    // number=7: 7, 'P' gap, 7 again
    number = 8'd7;
    tick_mode = 0;
    wait_show(7, 200);
    check("p7_seg", 32'(seg), 32'h07);
    check("p7_dp", 32'(dp), 32'h0);
    wait_gap_p(200);
    check("p7_gap_fv", 32'(factor_value), 32'h0);
    wait_show(7, 200);
    check("p7_again", 32'(seg), 32'h07);

    // entry-cycle tick does not count: with a tick every clock an item holds
    // exactly DWELL_TICKS clocks
    tick_mode = 2;
    wait_gap_p(200);
    wait_show(7, 200);
    cnt = 1;
    while (showing_factor && cnt < 50) begin
      @(negedge clk);
      if (showing_factor) cnt++;
    end
    check("entry_tick_dwell", 32'(cnt), 32'(DWELL_TICKS));

    // reset in the middle of SHOW
    tick_mode = 0;
    wait_show(7, 200);
    reset = 1'b1;
    @(negedge clk);
    check("rst_show_seg", 32'(seg), 32'h0);
    check("rst_show_sf", 32'(showing_factor), 32'h0);
    check("rst_show_fv", 32'(factor_value), 32'h0);
    reset = 1'b0;

    // random phase, model compare runs every cycle
    for (int it = 0; it < 30; it++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      number = 8'd0;
      else if (r == 1) number = 8'($urandom_range(1, 3));
      else if (r < 5)  number = 8'($urandom_range(0, 40));
      else             number = 8'($urandom_range(0, 255));
      tick_mode = int'($urandom_range(0, 2));
      hold = int'($urandom_range(2, 300));
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        reset = ($urandom_range(0, 199) == 0);
      end
      reset = 1'b0;
    end
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
